beep_sequencer: RTL and testbench

- Generates the `open512` / `open1k` tone-request levels consumed by the team's beeper block. It is the producer side of that interface.
- Watches the BCD time-of-day from the clock counter. From it, it issues two things:
  - an hourly chime: four low tones, then one high tone at the top of the hour;
  - a gated alarm ring, which stops on user acknowledge, on alarm disable, or on timeout.
- Sits between the time counter/alarm-setting logic and the beeper.

---
 rtl/beep_pkg.sv | 28 ++
 rtl/ring_pattern_gen.sv | 80 ++++++++
 rtl/beep_sequencer.sv | 101 ++++++++++
 tb/tb_beep_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared types and BCD time constants for the beep sequencer.
package beep_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RING = 1'b1
  } state_t;

  localparam logic [7:0] SEC_00 = 8'h00;
  localparam logic [7:0] MIN_59 = 8'h59;
  localparam logic [7:0] SEC_59 = 8'h59;

  localparam logic [3:0][7:0] CHIME_LO_SECS = {8'h57, 8'h55, 8'h53, 8'h51};

  function automatic logic is_chime_lo_sec(input logic [7:0] sec);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sec == CHIME_LO_SECS[i]) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/ring_pattern_gen.sv
// Alarm ring timing: total ring length and the on/off cadence of the high tone.
// tone_on and done are next-cycle views so the parent can register them with 1-clk latency.
module ring_pattern_gen #(
  parameter int RING_SECONDS = 60,
  parameter int ON_SECONDS   = 1,
  parameter int OFF_SECONDS  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic tick_1hz,
  output logic tone_on,
  output logic done
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);
  localparam logic [3:0] ON_LAST   = 4'(ON_SECONDS - 1);
  localparam logic [3:0] OFF_LAST  = 4'(OFF_SECONDS - 1);

  logic       running;
  logic [7:0] ring_cnt;
  logic [3:0] phase_cnt;
  logic       phase_on;

  logic       running_nxt;
  logic [7:0] ring_cnt_nxt;
  logic [3:0] phase_cnt_nxt;
  logic       phase_on_nxt;
  logic       phase_end;

  assign done    = running & tick_1hz & (ring_cnt == RING_LAST);
  assign tone_on = phase_on_nxt;

  // Next-state for the ring counters; start beats stop beats a tick.
  always_comb begin
    phase_end     = (phase_cnt == (phase_on ? ON_LAST : OFF_LAST));
    running_nxt   = running;
    ring_cnt_nxt  = ring_cnt;
    phase_cnt_nxt = phase_cnt;
    phase_on_nxt  = phase_on;
    if (start) begin
      running_nxt   = 1'b1;
      ring_cnt_nxt  = 8'd0;
      phase_cnt_nxt = 4'd0;
      phase_on_nxt  = 1'b1;
    end else if (stop || done) begin
      running_nxt   = 1'b0;
      ring_cnt_nxt  = 8'd0;
      phase_cnt_nxt = 4'd0;
      phase_on_nxt  = 1'b0;
    end else if (running && tick_1hz) begin
      ring_cnt_nxt = ring_cnt + 8'd1;
      if (phase_end) begin
        phase_on_nxt  = ~phase_on;
        phase_cnt_nxt = 4'd0;
      end else begin
        phase_cnt_nxt = phase_cnt + 4'd1;
      end
    end else begin
      running_nxt = running;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running   <= 1'b0;
      ring_cnt  <= 8'd0;
      phase_cnt <= 4'd0;
      phase_on  <= 1'b0;
    end else begin
      running   <= running_nxt;
      ring_cnt  <= ring_cnt_nxt;
      phase_cnt <= phase_cnt_nxt;
      phase_on  <= phase_on_nxt;
    end
  end

endmodule

// File: rtl/beep_sequencer.sv
// Hourly chime and gated alarm ring, producing tone-request levels for the beeper.
module beep_sequencer
  import beep_pkg::*;
#(
  parameter int RING_SECONDS = 60,
  parameter int ON_SECONDS   = 1,
  parameter int OFF_SECONDS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [7:0] hour_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic       chime_en,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hour_bcd,
  input  logic [7:0] alarm_min_bcd,
  input  logic       ack,
  output logic       open512,
  output logic       open1k,
  output logic       ringing
);

  state_t state;
  state_t state_nxt;
  logic   match;
  logic   match_q;
  logic   trigger;
  logic   chime_hit_lo;
  logic   chime_hit_hi;
  logic   start;
  logic   stop;
  logic   tone_on;
  logic   done;

  // Edge detect on the match so a held :00 second (e.g. after ack) cannot re-arm.
  assign match   = alarm_en & (hour_bcd == alarm_hour_bcd) & (min_bcd == alarm_min_bcd)
                   & (sec_bcd == SEC_00);
  assign trigger = match & ~match_q;

  assign chime_hit_lo = chime_en & (min_bcd == MIN_59) & is_chime_lo_sec(sec_bcd);
  assign chime_hit_hi = chime_en & (min_bcd == MIN_59) & (sec_bcd == SEC_59);

  assign start = (state == IDLE) & trigger;
  assign stop  = (state == RING) & (ack | ~alarm_en);

  ring_pattern_gen #(
    .RING_SECONDS(RING_SECONDS),
    .ON_SECONDS  (ON_SECONDS),
    .OFF_SECONDS (OFF_SECONDS)
  ) u_pattern (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .tick_1hz(tick_1hz),
    .tone_on (tone_on),
    .done    (done)
  );

  // Next-state decode for the alarm FSM.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (trigger) begin
          state_nxt = RING;
        end else begin
          state_nxt = IDLE;
        end
      end
      RING: begin
        if (ack || !alarm_en || done) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RING;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, match history and registered tone outputs; the alarm masks the chime.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      match_q <= 1'b0;
      ringing <= 1'b0;
      open1k  <= 1'b0;
      open512 <= 1'b0;
    end else begin
      state   <= state_nxt;
      match_q <= match;
      ringing <= (state_nxt == RING);
      open1k  <= (state_nxt == RING) ? tone_on : chime_hit_hi;
      open512 <= (state_nxt != RING) & chime_hit_lo;
    end
  end

endmodule

// File: tb/tb_beep_sequencer.sv
// Scoreboard bench: two sequencers (default and 2/3/10 cadence) against a seconds-level model.
module tb_beep_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       chime_en = 1'b0;
  logic       alarm_en = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] hour_bcd = 8'h00;
  logic [7:0] min_bcd = 8'h00;
  logic [7:0] sec_bcd = 8'h00;
  logic [7:0] alarm_hour_bcd = 8'h00;
  logic [7:0] alarm_min_bcd = 8'h00;
  logic       open512_a, open1k_a, ringing_a;
  logic       open512_b, open1k_b, ringing_b;

  int hh = 0, mm = 0, ss = 0, ah = 0, am = 0;
  int checks = 0;
  int errors = 0;

  // Per-instance parameters and model state: ring is a count of elapsed ticks.
  int p_ring[2] = '{60, 10};
  int p_on[2]   = '{1, 2};
  int p_off[2]  = '{1, 3};
  bit ring_m[2] = '{1'b0, 1'b0};
  int elapsed_m[2] = '{0, 0};
  bit prev_match = 1'b0;
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  beep_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .chime_en(chime_en), .alarm_en(alarm_en),
    .alarm_hour_bcd(alarm_hour_bcd), .alarm_min_bcd(alarm_min_bcd),
    .ack(ack), .open512(open512_a), .open1k(open1k_a), .ringing(ringing_a)
  );

  beep_sequencer #(.RING_SECONDS(10), .ON_SECONDS(2), .OFF_SECONDS(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .chime_en(chime_en), .alarm_en(alarm_en),
    .alarm_hour_bcd(alarm_hour_bcd), .alarm_min_bcd(alarm_min_bcd),
    .ack(ack), .open512(open512_b), .open1k(open1k_b), .ringing(ringing_b)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Seconds-level model: expected {ringing, open1k, open512} after the coming edge.
  task automatic model_and_push();
    bit match, trig, lo, hi, tone;
    logic [2:0] e;
    match = alarm_en && (hh == ah) && (mm == am) && (ss == 0);
    trig  = match && !prev_match;
    lo = chime_en && (mm == 59) && (ss == 51 || ss == 53 || ss == 55 || ss == 57);
    hi = chime_en && (mm == 59) && (ss == 59);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ring_m[k] = 1'b0;
        elapsed_m[k] = 0;
      end else if (ring_m[k]) begin
        if (ack || !alarm_en) ring_m[k] = 1'b0;
        else if (tick_1hz) begin
          elapsed_m[k] = elapsed_m[k] + 1;
          if (elapsed_m[k] == p_ring[k]) ring_m[k] = 1'b0;
        end
      end else if (trig) begin
        ring_m[k] = 1'b1;
        elapsed_m[k] = 0;
      end
      tone = (elapsed_m[k] % (p_on[k] + p_off[k])) < p_on[k];
      if (!rst_n) e = 3'b000;
      else if (ring_m[k]) e = {1'b1, tone, 1'b0};
      else e = {1'b0, hi, lo};
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    prev_match = rst_n ? match : 1'b0;
  endtask

  task automatic clk_step();
    hour_bcd = to_bcd(hh);
    min_bcd  = to_bcd(mm);
    sec_bcd  = to_bcd(ss);
    alarm_hour_bcd = to_bcd(ah);
    alarm_min_bcd  = to_bcd(am);
    model_and_push();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic adv_time();
    ss = ss + 1;
    if (ss == 60) begin ss = 0; mm = mm + 1; end
    if (mm == 60) begin mm = 0; hh = hh + 1; end
    if (hh == 24) hh = 0;
  endtask

  // One second: tick pulse, then the time update on the following clk.
  task automatic sec(input bit advance, input int gap);
    tick_1hz = 1'b1;
    clk_step();
    tick_1hz = 1'b0;
    if (advance) adv_time();
    clk_step();
    idle(gap);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    clk_step();
    ack = 1'b0;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hh = h; mm = m; ss = s;
  endtask

  task automatic check_out(input string tag, input logic [2:0] exp, input logic [2:0] act);
    string nm[3] = '{"open512", "open1k", "ringing"};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (act[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s_%s at %0t: got %b expected %b", tag, nm[i], $time, act[i], exp[i]);
      end
    end
    checks++;
    if (act[0] === 1'b1 && act[1] === 1'b1) begin
      errors++;
      $display("FAIL %s_exclusive at %0t: got open512=1 open1k=1 expected at most one", tag, $time);
    end
  endtask

  // Monitor: every edge the DUT presents new outputs; compare against the queued model result.
  always @(posedge clk) begin
    #1;
    if (q0.size() > 0) check_out("a", q0.pop_front(), {ringing_a, open1k_a, open512_a});
    if (q1.size() > 0) check_out("b", q1.pop_front(), {ringing_b, open1k_b, open512_b});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Chime across the top of the hour.
    chime_en = 1'b1;
    alarm_en = 1'b0;
    set_time(12, 59, 50);
    for (int i = 0; i < 11; i++) sec(1'b1, 2);

    // Alarm at 07:30 running to timeout on both cadences.
    ah = 7; am = 30; alarm_en = 1'b1;
    set_time(7, 29, 58);
    idle(2);
    sec(1'b1, 2);
    sec(1'b1, 2);
    for (int i = 0; i < 62; i++) sec(1'b1, 1);

    // Ack while the match second is held: no re-trigger.
    set_time(7, 29, 59);
    idle(2);
    sec(1'b1, 2);
    for (int i = 0; i < 5; i++) sec(1'b0, 1);
    pulse_ack();
    idle(3);
    sec(1'b0, 2);
    sec(1'b0, 2);
    sec(1'b1, 2);
    pulse_ack();
    idle(2);

    // Ring overlapping the chime window.
    ah = 6; am = 0;
    set_time(5, 59, 59);
    idle(2);
    sec(1'b1, 1);
    sec(1'b1, 1);
    sec(1'b1, 1);
    set_time(6, 59, 50);
    for (int i = 0; i < 11; i++) sec(1'b1, 1);
    alarm_en = 1'b0;
    idle(3);

    // Disable mid-ring, then reset mid-ring.
    ah = 8; am = 15; alarm_en = 1'b1;
    set_time(8, 14, 59);
    idle(2);
    sec(1'b1, 2);
    for (int i = 0; i < 3; i++) sec(1'b1, 1);
    alarm_en = 1'b0;
    idle(3);
    alarm_en = 1'b1;
    set_time(8, 14, 59);
    idle(2);
    sec(1'b1, 2);
    sec(1'b1, 1);
    sec(1'b1, 1);
    rst_n = 1'b0;
    clk_step();
    rst_n = 1'b1;
    idle(3);
    sec(1'b1, 2);

    // Randomized mix of chime windows, alarm hits, acks and enables.
    for (int it = 0; it < 40; it++) begin
      chime_en = ($urandom_range(0, 3) != 0);
      alarm_en = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        set_time($urandom_range(0, 23), 59, $urandom_range(48, 58));
      end else begin
        ah = $urandom_range(0, 23);
        am = $urandom_range(0, 59);
        set_time(ah, am, 0);
      end
      idle($urandom_range(1, 3));
      for (int s = 0; s < int'($urandom_range(2, 12)); s++) begin
        if ($urandom_range(0, 7) == 0) pulse_ack();
        if ($urandom_range(0, 11) == 0) alarm_en = ~alarm_en;
        sec($urandom_range(0, 5) != 0, $urandom_range(0, 3));
      end
      set_time(12, 0, 30);
      idle(2);
    end

    idle(3);
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
